// File: rtl/nes_pkg.sv
// Shared types and constants for the MMC1-style cartridge mapper.
// The enums name the control-register fields and the serial load targets.
package nes_pkg;

  typedef enum logic [1:0] {
    MIR_ONE_LO = 2'd0,
    MIR_ONE_HI = 2'd1,
    MIR_VERT   = 2'd2,
    MIR_HORZ   = 2'd3
  } mirror_e;

  typedef enum logic [1:0] {
    PRG_32K_A     = 2'd0,
    PRG_32K_B     = 2'd1,
    PRG_FIX_FIRST = 2'd2,
    PRG_FIX_LAST  = 2'd3
  } prg_mode_e;

  typedef enum logic [1:0] {
    REG_CTRL = 2'd0,
    REG_CHR0 = 2'd1,
    REG_CHR1 = 2'd2,
    REG_PRG  = 2'd3
  } reg_sel_e;

  localparam logic [4:0] CTRL_RESET  = 5'h0C;
  localparam logic [4:0] SHIFT_EMPTY = 5'b10000;

  function automatic logic [4:0] shift_in(input logic [4:0] shift, input logic d0);
    return {d0, shift[4:1]};
  endfunction

endpackage

// File: rtl/mmc1_serial_loader.sv
// Captures CPU writes to $8000-$FFFF, commits them on the m2 falling edge and
// assembles the 5-bit serial value; drops the second write of an RMW pair.
module mmc1_serial_loader
  import nes_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       m2_i,
  input  logic       rw_i,
  input  logic       n_rom_sel_i,
  input  logic       d7_i,
  input  logic       d0_i,
  input  logic [1:0] sel_i,
  output logic       load_o,
  output reg_sel_e   target_o,
  output logic [4:0] value_o,
  output logic       mode_reset_o
);

  logic       m2_q;
  logic       cap_valid_q, cap_valid_d;
  logic       cap_d7_q, cap_d7_d;
  logic       cap_d0_q, cap_d0_d;
  logic [1:0] cap_sel_q, cap_sel_d;
  logic       wrote_last_q, wrote_last_d;
  logic [4:0] shift_q, shift_d;

  logic       write_cyc;
  logic       m2_fall;
  logic       commit;
  logic [4:0] shifted;
  logic       load;
  logic       mode_reset;

  // Capture, edge detect, consecutive-write filter and shift next state.
  always_comb begin
    write_cyc    = m2_i & ~rw_i & ~n_rom_sel_i;
    m2_fall      = m2_q & ~m2_i;
    commit       = m2_fall & cap_valid_q & ~wrote_last_q;
    shifted      = shift_in(shift_q, cap_d0_q);
    cap_valid_d  = cap_valid_q;
    cap_d7_d     = cap_d7_q;
    cap_d0_d     = cap_d0_q;
    cap_sel_d    = cap_sel_q;
    wrote_last_d = wrote_last_q;
    shift_d      = shift_q;
    load         = 1'b0;
    mode_reset   = 1'b0;

    if (write_cyc) begin
      cap_valid_d = 1'b1;
      cap_d7_d    = d7_i;
      cap_d0_d    = d0_i;
      cap_sel_d   = sel_i;
    end else if (m2_fall) begin
      cap_valid_d = 1'b0;
    end else begin
      cap_valid_d = cap_valid_q;
    end

    // A write cycle arms the filter; any completed non-write cycle disarms it.
    if (m2_fall) begin
      wrote_last_d = cap_valid_q;
    end else begin
      wrote_last_d = wrote_last_q;
    end

    if (commit) begin
      if (cap_d7_q) begin
        shift_d    = SHIFT_EMPTY;
        mode_reset = 1'b1;
      end else if (shift_q[0]) begin
        shift_d = SHIFT_EMPTY;
        load    = 1'b1;
      end else begin
        shift_d = shifted;
      end
    end else begin
      shift_d = shift_q;
    end
  end

  // Loader state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      m2_q         <= 1'b0;
      cap_valid_q  <= 1'b0;
      cap_d7_q     <= 1'b0;
      cap_d0_q     <= 1'b0;
      cap_sel_q    <= 2'b00;
      wrote_last_q <= 1'b0;
      shift_q      <= SHIFT_EMPTY;
    end else begin
      m2_q         <= m2_i;
      cap_valid_q  <= cap_valid_d;
      cap_d7_q     <= cap_d7_d;
      cap_d0_q     <= cap_d0_d;
      cap_sel_q    <= cap_sel_d;
      wrote_last_q <= wrote_last_d;
      shift_q      <= shift_d;
    end
  end

  assign load_o       = load;
  assign mode_reset_o = mode_reset;
  assign target_o     = reg_sel_e'(cap_sel_q);
  assign value_o      = shifted;

endmodule

// File: rtl/cart_mmc1.sv
// MMC1-style cartridge mapper: bank registers loaded serially from CPU writes,
// PRG/CHR address extension, PRG-RAM enable and CIRAM mirroring.
module cart_mmc1
  import nes_pkg::*;
#(
  parameter int PRG_BANK_BITS = 4,
  parameter int CHR_BANK_BITS = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      m2,
  input  logic                      rw,
  input  logic                      n_rom_sel,
  input  logic [14:0]               cpu_addr,
  input  logic [7:0]                cpu_data,
  input  logic [13:0]               ppu_addr,
  output logic [PRG_BANK_BITS+13:0] prg_addr,
  output logic                      n_prg_rom_ce,
  output logic                      n_prg_ram_ce,
  output logic [CHR_BANK_BITS+11:0] chr_addr,
  output logic                      n_vram_cs,
  output logic                      n_vram_a10,
  output logic                      n_irq
);

  logic [4:0] ctrl_q, ctrl_d;
  logic [4:0] chr0_q, chr0_d;
  logic [4:0] chr1_q, chr1_d;
  logic [4:0] prg_q, prg_d;

  logic       load;
  logic       mode_reset;
  reg_sel_e   target;
  logic [4:0] value;

  logic [PRG_BANK_BITS-1:0] prg_bank;
  logic [CHR_BANK_BITS-1:0] chr_bank;
  logic                     a10;
  logic                     unused_data;

  assign unused_data = ^cpu_data[6:1];

  mmc1_serial_loader u_loader (
    .clk          (clk),
    .reset        (reset),
    .m2_i         (m2),
    .rw_i         (rw),
    .n_rom_sel_i  (n_rom_sel),
    .d7_i         (cpu_data[7]),
    .d0_i         (cpu_data[0]),
    .sel_i        (cpu_addr[14:13]),
    .load_o       (load),
    .target_o     (target),
    .value_o      (value),
    .mode_reset_o (mode_reset)
  );

  // Bank register next state from loader strobes.
  always_comb begin
    ctrl_d = ctrl_q;
    chr0_d = chr0_q;
    chr1_d = chr1_q;
    prg_d  = prg_q;
    if (mode_reset) begin
      ctrl_d = {ctrl_q[4], 2'b11, ctrl_q[1:0]};
    end else if (load) begin
      case (target)
        REG_CTRL: ctrl_d = value;
        REG_CHR0: chr0_d = value;
        REG_CHR1: chr1_d = value;
        REG_PRG:  prg_d  = value;
        default:  ctrl_d = ctrl_q;
      endcase
    end else begin
      ctrl_d = ctrl_q;
    end
  end

  // Bank registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q <= CTRL_RESET;
      chr0_q <= 5'h00;
      chr1_q <= 5'h00;
      prg_q  <= 5'h00;
    end else begin
      ctrl_q <= ctrl_d;
      chr0_q <= chr0_d;
      chr1_q <= chr1_d;
      prg_q  <= prg_d;
    end
  end

  // Address-path bank selection and mirroring, combinational on live addresses.
  always_comb begin
    prg_bank = '0;
    chr_bank = '0;
    a10      = 1'b0;

    case (prg_mode_e'(ctrl_q[3:2]))
      PRG_32K_A, PRG_32K_B: prg_bank = PRG_BANK_BITS'({prg_q[3:1], cpu_addr[14]});
      PRG_FIX_FIRST:        prg_bank = cpu_addr[14] ? PRG_BANK_BITS'(prg_q[3:0]) : '0;
      PRG_FIX_LAST:         prg_bank = cpu_addr[14] ? '1 : PRG_BANK_BITS'(prg_q[3:0]);
      default:              prg_bank = '0;
    endcase

    if (ctrl_q[4]) begin
      chr_bank = ppu_addr[12] ? CHR_BANK_BITS'(chr1_q) : CHR_BANK_BITS'(chr0_q);
    end else begin
      chr_bank = CHR_BANK_BITS'({chr0_q[4:1], ppu_addr[12]});
    end

    case (mirror_e'(ctrl_q[1:0]))
      MIR_ONE_LO: a10 = 1'b0;
      MIR_ONE_HI: a10 = 1'b1;
      MIR_VERT:   a10 = ppu_addr[10];
      MIR_HORZ:   a10 = ppu_addr[11];
      default:    a10 = 1'b0;
    endcase
  end

  assign prg_addr     = {prg_bank, cpu_addr[13:0]};
  assign chr_addr     = {chr_bank, ppu_addr[11:0]};
  assign n_vram_a10   = a10;
  assign n_vram_cs    = ~ppu_addr[13];
  assign n_prg_rom_ce = n_rom_sel | ~rw;
  assign n_prg_ram_ce = ~(m2 & n_rom_sel & (cpu_addr[14:13] == 2'b11) & ~prg_q[4]);
  assign n_irq        = 1'b1;

endmodule

// File: doc/cart_mmc1.md
# cart_mmc1

Cartridge-side responder for the console's CPU and PPU buses: decodes CPU writes to $8000–$FFFF into MMC1-style serial bank registers and drives PRG/CHR address extension, PRG-RAM select and CIRAM mirroring (n_vram_cs / n_vram_a10) back to the console. It sits on the far end of the cartridge connector, consuming m2 / rw / n_rom_sel / cpu_addr / cpu_data and ppu_addr, and replaces a fixed-wiring cartridge in simulation and FPGA builds.

## Interface
- PRG_BANK_BITS, 4: PRG 16 KB bank-select width (256 KB PRG).
- CHR_BANK_BITS, 5: CHR 4 KB bank-select width (128 KB CHR).
- clk  in  1  system clock, same clock that generates m2 (m2 is synchronous to clk).
- reset  in  1  synchronous, active-high.
- m2  in  1  CPU phase-2 qualifier.
- rw  in  1  CPU read(1)/write(0).
- n_rom_sel  in  1  low while m2 high and A15=1.
- cpu_addr  in  15  CPU A14..A0.
- cpu_data  in  8  CPU data (cartridge only samples; never drives).
- ppu_addr  in  14  PPU address, true polarity.
- prg_addr  out  PRG_BANK_BITS+14  PRG ROM address.
- n_prg_rom_ce  out  1  PRG ROM chip enable.
- n_prg_ram_ce  out  1  PRG RAM ($6000–$7FFF) chip enable.
- chr_addr  out  CHR_BANK_BITS+12  CHR address.
- n_vram_cs  out  1  CIRAM select, low when ppu_addr[13]=1.
- n_vram_a10  out  1  CIRAM A10 level (non-inverted; name kept for connector compatibility).
- n_irq  out  1  held 1.

## Operation
- Registers (5 bit): control (reset 5'h0C), chr0, chr1, prg (reset 0); shift (reset 5'b10000, bit-4 sentinel).
- Write cycle: m2=1, rw=0, n_rom_sel=0. Capture cpu_data[7], cpu_data[0], cpu_addr[14:13] every clk the condition holds; commit on m2 falling edge (m2_q=1, m2=0).
- Consecutive-write filter: flag wrote_last set at each m2 fall ending a write cycle, cleared at each m2 fall ending a non-write cycle. Commit ignored when wrote_last already set (RMW double write: only first counts).
- Commit with d7=1: shift <= 10000, control[3:2] <= 2'b11; other bits unchanged.
- Commit with d7=0: if shift[0]=0, shift <= {d0, shift[4:1]}; else load {d0, shift[4:1]} into target by addr[14:13] (00 control, 01 chr0, 10 chr1, 11 prg), shift <= 10000.
- PRG mode control[3:2]: 0/1 32 KB: bank = {prg[3:1], cpu_addr[14]}; 2: cpu_addr[14]? prg[3:0] : 0; 3: cpu_addr[14]? all-ones : prg[3:0]. prg_addr = {bank, cpu_addr[13:0]}.
- CHR mode control[4]: 0 8 KB: bank = {chr0[4:1], ppu_addr[12]}; 1: ppu_addr[12]? chr1 : chr0. chr_addr = {bank, ppu_addr[11:0]}.
- Mirroring control[1:0]: 0 A10=0; 1 A10=1; 2 vertical A10=ppu_addr[10]; 3 horizontal A10=ppu_addr[11].
- n_prg_rom_ce = n_rom_sel | ~rw. n_prg_ram_ce = ~(m2 & n_rom_sel & cpu_addr[14:13]==2'b11 & ~prg[4]).

## Timing
- All bank/mirror/ce outputs combinational from registers plus live addresses; no address-path latency.
- Register update visible first clk after the m2 falling-edge sample.
- Reset: registers to reset values, wrote_last=0, capture cleared; outputs then prg_addr={1111, cpu_addr[13:0]} when cpu_addr[14]=1, else {0000, …}; n_irq=1.
- Reset mid-sequence discards partial shift; reset coinciding with commit: reset wins.
- m2 falling without a preceding write cycle: no register change.

## Structure
- Shared package nes_pkg: mirroring enum, PRG mode enum, CTRL_RESET=5'h0C, SHIFT_EMPTY=5'b10000.
- One sub-module: mmc1_serial_loader (capture, edge detect, filter, shift; outputs load strobe, target, 5-bit value). Bank muxing stays in cart_mmc1.

## Test plan
- Reset, read $C000 and $8000 -> prg_addr[17:14]=4'hF and 4'h0; n_vram_a10 = 0 (control=0C, mode 0).
- Five writes to $E000 of d0=1,0,1,0,0 on non-consecutive cycles -> prg=5'b00101; read $8000 -> prg_addr[17:14]=4'h5.
- Write $80 to $8000 after two serial bits -> shift empty, control=0x0C|old; next five writes load cleanly.
- Two writes in adjacent CPU cycles (RMW) -> only first shifts; five RMW ops load one register from first-write bits only.
- Control=5'b10011, chr1=5'h07, ppu_addr=$1ABC -> chr_addr=17'h07ABC; ppu_addr=$2C00 -> n_vram_cs=0, n_vram_a10=1.
- prg[4]=1, access $6000 with m2=1 -> n_prg_ram_ce=1; prg[4]=0 -> 0; assert reset after three serial bits -> shift=10000.
